// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Access-size encodings, funct3 opcodes and the alignment rule live here.
package riscv_lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_FAULT = 3'd4
   } lsu_state_e;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   // An access must be naturally aligned inside its doubleword.
   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = off[0];
         SZ_W:    bad = (off[1:0] != 2'b00);
         SZ_D:    bad = (off != 3'b000);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: byte-enable generation, store lane shift and load right-shift.
// Purely combinational; the caller picks which offset drives each path.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [1:0]                    size,
   input  logic [$clog2(XLEN/8)-1:0]     off,
   input  logic [XLEN-1:0]               wdata,
   input  logic [$clog2(XLEN/8)-1:0]     rd_off,
   input  logic [XLEN-1:0]               mem_rdata,
   output logic [XLEN/8-1:0]             be,
   output logic [XLEN-1:0]               lane_wdata,
   output logic [XLEN-1:0]               rdata
);

   localparam int NB = XLEN / 8;

   logic [NB-1:0] be_base_s;

   // Unshifted byte-enable mask for the access size.
   always_comb begin
      be_base_s = {NB{1'b0}};
      case (size)
         SZ_B:    be_base_s = NB'(8'h01);
         SZ_H:    be_base_s = NB'(8'h03);
         SZ_W:    be_base_s = NB'(8'h0F);
         SZ_D:    be_base_s = {NB{1'b1}};
         default: be_base_s = {NB{1'b0}};
      endcase
   end

   assign be         = be_base_s << off;
   assign lane_wdata = wdata << {off, 3'b000};
   assign rdata      = mem_rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/riscv_lsu.sv
// MEM-stage load/store unit: one doubleword bus access per instruction on a req/gnt/rvalid bus,
// stalling the pipeline until the access (or an alignment fault) completes.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int ADDR_W = 64
) (
   input  logic                 i_riscv_lsu_clk,
   input  logic                 i_riscv_lsu_rst_n,
   input  logic                 i_riscv_lsu_valid,
   input  logic                 i_riscv_lsu_load,
   input  logic                 i_riscv_lsu_store,
   input  logic [2:0]           i_riscv_lsu_funct3,
   input  logic [ADDR_W-1:0]    i_riscv_lsu_addr,
   input  logic [XLEN-1:0]      i_riscv_lsu_wdata,
   output logic                 o_riscv_lsu_stall,
   output logic                 o_riscv_lsu_done,
   output logic                 o_riscv_lsu_misaligned,
   output logic [XLEN-1:0]      o_riscv_lsu_rdata,
   output logic [2:0]           o_riscv_lsu_memext_sel,
   output logic                 o_riscv_lsu_mem_req,
   output logic                 o_riscv_lsu_mem_we,
   output logic [ADDR_W-1:0]    o_riscv_lsu_mem_addr,
   output logic [XLEN-1:0]      o_riscv_lsu_mem_wdata,
   output logic [XLEN/8-1:0]    o_riscv_lsu_mem_be,
   input  logic                 i_riscv_lsu_mem_gnt,
   input  logic                 i_riscv_lsu_mem_rvalid,
   input  logic [XLEN-1:0]      i_riscv_lsu_mem_rdata
);

   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);

   lsu_state_e      state_r;
   logic            done_r;
   logic            misaligned_r;
   logic            req_r;
   logic            we_r;
   logic [ADDR_W-1:0] addr_r;
   logic [XLEN-1:0] wdata_r;
   logic [NB-1:0]   be_r;
   logic [XLEN-1:0] rdata_r;
   logic [2:0]      sel_r;
   logic [2:0]      funct3_r;
   logic [OW-1:0]   rd_off_r;
   logic            ld_r;

   logic            op_s;
   logic            fault_s;
   logic [OW-1:0]   off_s;
   logic [NB-1:0]   be_s;
   logic [XLEN-1:0] lane_wdata_s;
   logic [XLEN-1:0] shifted_s;

   assign op_s    = i_riscv_lsu_valid & (i_riscv_lsu_load | i_riscv_lsu_store);
   assign off_s   = i_riscv_lsu_addr[OW-1:0];
   assign fault_s = (i_riscv_lsu_load & i_riscv_lsu_store)
                  | misaligned(i_riscv_lsu_funct3[1:0], i_riscv_lsu_addr[2:0]);

   // Store path steers with the live offset; load path uses the offset captured at request time.
   riscv_lsu_align #(.XLEN(XLEN)) u_align (
      .size       (i_riscv_lsu_funct3[1:0]),
      .off        (off_s),
      .wdata      (i_riscv_lsu_wdata),
      .rd_off     (rd_off_r),
      .mem_rdata  (i_riscv_lsu_mem_rdata),
      .be         (be_s),
      .lane_wdata (lane_wdata_s),
      .rdata      (shifted_s)
   );

   // Access sequencer with all bus and result outputs registered.
   always_ff @(posedge i_riscv_lsu_clk or negedge i_riscv_lsu_rst_n) begin
      if (!i_riscv_lsu_rst_n) begin
         state_r      <= ST_IDLE;
         done_r       <= 1'b0;
         misaligned_r <= 1'b0;
         req_r        <= 1'b0;
         we_r         <= 1'b0;
         addr_r       <= {ADDR_W{1'b0}};
         wdata_r      <= {XLEN{1'b0}};
         be_r         <= {NB{1'b0}};
         rdata_r      <= {XLEN{1'b0}};
         sel_r        <= 3'b000;
         funct3_r     <= 3'b000;
         rd_off_r     <= {OW{1'b0}};
         ld_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r       <= 1'b0;
               misaligned_r <= 1'b0;
               if (op_s && fault_s) begin
                  state_r      <= ST_FAULT;
                  done_r       <= 1'b1;
                  misaligned_r <= 1'b1;
               end else if (op_s) begin
                  state_r  <= ST_REQ;
                  req_r    <= 1'b1;
                  we_r     <= i_riscv_lsu_store;
                  addr_r   <= {i_riscv_lsu_addr[ADDR_W-1:OW], {OW{1'b0}}};
                  wdata_r  <= lane_wdata_s;
                  be_r     <= be_s;
                  funct3_r <= i_riscv_lsu_funct3;
                  rd_off_r <= off_s;
                  ld_r     <= i_riscv_lsu_load;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (i_riscv_lsu_mem_gnt) begin
                  req_r <= 1'b0;
                  if (!ld_r) begin
                     state_r <= ST_RESP;
                     done_r  <= 1'b1;
                  end else if (i_riscv_lsu_mem_rvalid) begin
                     state_r <= ST_RESP;
                     done_r  <= 1'b1;
                     rdata_r <= shifted_s;
                     sel_r   <= funct3_r;
                  end else begin
                     state_r <= ST_WAIT;
                  end
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_WAIT: begin
               if (i_riscv_lsu_mem_rvalid) begin
                  state_r <= ST_RESP;
                  done_r  <= 1'b1;
                  rdata_r <= shifted_s;
                  sel_r   <= funct3_r;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_RESP: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
            ST_FAULT: begin
               state_r      <= ST_IDLE;
               done_r       <= 1'b0;
               misaligned_r <= 1'b0;
            end
            default: begin
               state_r      <= ST_IDLE;
               done_r       <= 1'b0;
               misaligned_r <= 1'b0;
               req_r        <= 1'b0;
            end
         endcase
      end
   end

   // Stall drops in the done cycle so the pipeline advances on that edge.
   assign o_riscv_lsu_stall      = op_s & ~done_r;
   assign o_riscv_lsu_done       = done_r;
   assign o_riscv_lsu_misaligned = misaligned_r;
   assign o_riscv_lsu_rdata      = rdata_r;
   assign o_riscv_lsu_memext_sel = sel_r;
   assign o_riscv_lsu_mem_req    = req_r;
   assign o_riscv_lsu_mem_we     = we_r;
   assign o_riscv_lsu_mem_addr   = addr_r;
   assign o_riscv_lsu_mem_wdata  = wdata_r;
   assign o_riscv_lsu_mem_be     = be_r;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: store lane steering, load alignment, faults, gnt backpressure, reset.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic        load;
   logic        store;
   logic [2:0]  funct3;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic        stall;
   logic        done;
   logic        mis;
   logic [63:0] rdata;
   logic [2:0]  sel;
   logic        req;
   logic        we;
   logic [63:0] maddr;
   logic [63:0] mwdata;
   logic [7:0]  be;
   logic        gnt;
   logic        rvalid;
   logic [63:0] mrdata;

   int checks;
   int failures;

   riscv_lsu #(.XLEN(64), .ADDR_W(64)) dut (
      .i_riscv_lsu_clk        (clk),
      .i_riscv_lsu_rst_n      (rst_n),
      .i_riscv_lsu_valid      (valid),
      .i_riscv_lsu_load       (load),
      .i_riscv_lsu_store      (store),
      .i_riscv_lsu_funct3     (funct3),
      .i_riscv_lsu_addr       (addr),
      .i_riscv_lsu_wdata      (wdata),
      .o_riscv_lsu_stall      (stall),
      .o_riscv_lsu_done       (done),
      .o_riscv_lsu_misaligned (mis),
      .o_riscv_lsu_rdata      (rdata),
      .o_riscv_lsu_memext_sel (sel),
      .o_riscv_lsu_mem_req    (req),
      .o_riscv_lsu_mem_we     (we),
      .o_riscv_lsu_mem_addr   (maddr),
      .o_riscv_lsu_mem_wdata  (mwdata),
      .o_riscv_lsu_mem_be     (be),
      .i_riscv_lsu_mem_gnt    (gnt),
      .i_riscv_lsu_mem_rvalid (rvalid),
      .i_riscv_lsu_mem_rdata  (mrdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs;
      valid = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'b000;
      addr = 64'h0; wdata = 64'h0; gnt = 1'b0; rvalid = 1'b0; mrdata = 64'h0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_n = 1'b0;
      #12;
      checks++; if ({stall, done, mis, req, we} !== 5'b00000) begin failures++; $display("FAIL reset_ctrl got=%b exp=%b", {stall, done, mis, req, we}, 5'b00000); end
      checks++; if ({rdata, maddr, mwdata} !== 192'h0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", rdata, maddr, mwdata); end
      checks++; if ({sel, be} !== 11'h000) begin failures++; $display("FAIL reset_sel_be got=%h/%h exp=0", sel, be); end
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_sb;
      valid = 1'b1; store = 1'b1; funct3 = F3_SB; addr = 64'h1003; wdata = 64'hAB; gnt = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_idle got=%b exp=1", stall); end
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL sb_req_idle got=%b exp=0", req); end
      step();
      checks++; if (req !== 1'b1 || we !== 1'b1) begin failures++; $display("FAIL sb_req_we got=%b%b exp=11", req, we); end
      checks++; if (maddr !== 64'h1000) begin failures++; $display("FAIL sb_addr got=%h exp=%h", maddr, 64'h1000); end
      checks++; if (be !== 8'h08) begin failures++; $display("FAIL sb_be got=%h exp=08", be); end
      checks++; if (mwdata !== 64'h00000000AB000000) begin failures++; $display("FAIL sb_wdata got=%h exp=%h", mwdata, 64'h00000000AB000000); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sb_done_early got=%b exp=0", done); end
      step();
      checks++; if (done !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL sb_done got=%b stall=%b exp=1/0", done, stall); end
      checks++; if (req !== 1'b0 || mis !== 1'b0) begin failures++; $display("FAIL sb_resp_req_mis got=%b%b exp=00", req, mis); end
      idle_inputs();
      step();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sb_done_pulse got=%b exp=0", done); end
   endtask

   task automatic test_lh_wait;
      valid = 1'b1; load = 1'b1; funct3 = F3_LH; addr = 64'h2006;
      step();
      checks++; if (req !== 1'b1 || we !== 1'b0) begin failures++; $display("FAIL lh_req_we got=%b%b exp=10", req, we); end
      checks++; if (be !== 8'hC0 || maddr !== 64'h2000) begin failures++; $display("FAIL lh_be_addr got=%h/%h exp=c0/2000", be, maddr); end
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      checks++; if (req !== 1'b0 || done !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL lh_wait1 got=%b%b%b exp=001", req, done, stall); end
      step();
      checks++; if (done !== 1'b0 || stall !== 1'b1) begin failures++; $display("FAIL lh_wait2 got=%b%b exp=01", done, stall); end
      rvalid = 1'b1; mrdata = 64'h8001000000000000;
      step();
      rvalid = 1'b0;
      checks++; if (done !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL lh_done got=%b stall=%b exp=1/0", done, stall); end
      checks++; if (rdata !== 64'h0000000000008001) begin failures++; $display("FAIL lh_rdata got=%h exp=%h", rdata, 64'h8001); end
      checks++; if (sel !== 3'b001) begin failures++; $display("FAIL lh_sel got=%b exp=001", sel); end
      idle_inputs();
      step();
      checks++; if (done !== 1'b0 || rdata !== 64'h8001) begin failures++; $display("FAIL lh_hold got=%b/%h exp=0/8001", done, rdata); end
   endtask

   task automatic test_misaligned;
      valid = 1'b1; load = 1'b1; funct3 = F3_LW; addr = 64'h3002; gnt = 1'b1;
      #1;
      checks++; if (stall !== 1'b1 || req !== 1'b0) begin failures++; $display("FAIL mis_pre got=%b%b exp=10", stall, req); end
      step();
      checks++; if (done !== 1'b1 || mis !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b%b exp=11", done, mis); end
      checks++; if (stall !== 1'b0 || req !== 1'b0) begin failures++; $display("FAIL mis_stall_req got=%b%b exp=00", stall, req); end
      idle_inputs();
      step();
      checks++; if ({done, mis, req} !== 3'b000) begin failures++; $display("FAIL mis_after got=%b exp=000", {done, mis, req}); end
   endtask

   task automatic test_sd_backpressure;
      valid = 1'b1; store = 1'b1; funct3 = F3_SD; addr = 64'h4000; wdata = 64'h1122334455667788;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++; if (req !== 1'b1 || stall !== 1'b1) begin failures++; $display("FAIL sd_req_%0d got=%b%b exp=11", i, req, stall); end
         checks++; if (maddr !== 64'h4000 || be !== 8'hFF || mwdata !== 64'h1122334455667788) begin failures++; $display("FAIL sd_fields_%0d got=%h/%h/%h", i, maddr, be, mwdata); end
         if (i == 3) gnt = 1'b1;
         step();
      end
      checks++; if (done !== 1'b1 || req !== 1'b0) begin failures++; $display("FAIL sd_done got=%b%b exp=10", done, req); end
      checks++; if (rdata !== 64'h8001 || sel !== 3'b001) begin failures++; $display("FAIL sd_rdata_hold got=%h/%b exp=8001/001", rdata, sel); end
      idle_inputs();
      step();
   endtask

   task automatic test_ld_same_cycle;
      valid = 1'b1; load = 1'b1; funct3 = F3_LD; addr = 64'h5000;
      gnt = 1'b1; rvalid = 1'b1; mrdata = 64'h0123456789ABCDEF;
      step();
      checks++; if (req !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ld_req got=%b%b exp=10", req, done); end
      step();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL ld_done got=%b exp=1", done); end
      checks++; if (rdata !== 64'h0123456789ABCDEF || sel !== 3'b011) begin failures++; $display("FAIL ld_rdata got=%h/%b exp=0123456789abcdef/011", rdata, sel); end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_in_wait;
      valid = 1'b1; load = 1'b1; funct3 = F3_LW; addr = 64'h6004; gnt = 1'b1;
      step();
      checks++; if (be !== 8'hF0) begin failures++; $display("FAIL rw_be got=%h exp=f0", be); end
      step();
      idle_inputs();
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({done, mis, req, we, stall} !== 5'b00000) begin failures++; $display("FAIL rw_ctrl got=%b exp=00000", {done, mis, req, we, stall}); end
      checks++; if (rdata !== 64'h0 || sel !== 3'b000 || be !== 8'h00 || maddr !== 64'h0) begin failures++; $display("FAIL rw_data got=%h/%b/%h/%h exp=0", rdata, sel, be, maddr); end
      step();
      rst_n = 1'b1;
      rvalid = 1'b1; mrdata = 64'hDEADBEEFCAFEF00D;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (done !== 1'b0 || req !== 1'b0 || rdata !== 64'h0) begin failures++; $display("FAIL rw_late_%0d got=%b%b/%h exp=00/0", i, done, req, rdata); end
      end
      rvalid = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_sb();
      test_lh_wait();
      test_misaligned();
      test_sd_backpressure();
      test_ld_same_cycle();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
